// File: rtl/conv_mxfp8tobf16.sv
// MX block to bf16 decoder: buffers one block of k narrow FP elements plus a
// shared scale exponent and streams it out as bf16 values, lanes per beat.
module conv_mxfp8tobf16 #(
  parameter int exp_width  = 3,
  parameter int man_width  = 2,
  parameter int bit_width  = 1 + exp_width + man_width,
  parameter int k          = 32,
  parameter int lanes      = 32,
  parameter bit sat        = 1'b1,
  parameter bit e4m3_spec  = (exp_width == 4) && (man_width == 3),
  localparam int nbeats    = k / lanes,
  localparam int bw        = (nbeats > 1) ? $clog2(nbeats) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [k-1:0][bit_width-1:0]      i_mx_vec,
  input  logic [7:0]                       i_mx_exp,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [lanes-1:0][15:0]           o_bf16_vec,
  output logic [bw-1:0]                    o_beat,
  output logic                             o_last
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;
  logic [bw-1:0] beat_q, beat_d;
  logic [nbeats-1:0][lanes-1:0][bit_width-1:0] blk_q;
  logic [7:0] x_q;
  logic busy, last, accept;

  // Result exponent and range checks are done in int so negative exponents
  // from deep subnormals with a small scale cannot wrap.
  function automatic logic [15:0] decode(input logic [bit_width-1:0] el,
                                         input logic [7:0] x);
    logic                 s;
    logic [exp_width-1:0] e;
    logic [man_width-1:0] m;
    logic [6:0]           mant;
    logic [15:0]          res;
    int                   r;
    int                   sh;
    s  = el[bit_width-1];
    e  = el[bit_width-2 -: exp_width];
    m  = el[man_width-1:0];
    sh = 0;
    for (int i = 0; i < man_width; i++) begin
      if (m[i]) sh = man_width - i;
    end
    if (e != '0) begin
      sh = 0;
      r  = int'(x) + int'(e);
    end else begin
      r  = int'(x) + 1 - sh;
    end
    // Shifting out the leading one leaves the subnormal fraction left-aligned.
    mant = 7'(({m, 7'b0} << sh) >> man_width);
    if (x == 8'hFF)                             res = 16'h7FC0;
    else if (e4m3_spec && (&e) && (&m))         res = 16'h7FC0;
    else if (!e4m3_spec && (&e))                res = (m != '0) ? 16'h7FC0 : {s, 15'h7F80};
    else if ((e == '0) && (m == '0))            res = {s, 15'h0000};
    else if (r >= 255)                          res = sat ? {s, 15'h7F7F} : {s, 15'h7F80};
    else if (r <= 0)                            res = {s, 15'h0000};
    else                                        res = {s, r[7:0], mant};
    return res;
  endfunction

  assign busy    = (state_q == BUSY);
  assign last    = busy && (beat_q == bw'(nbeats - 1));
  assign o_valid = busy;
  assign o_last  = last;
  assign o_beat  = busy ? beat_q : '0;
  assign o_ready = !busy || (i_ready && last);
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (accept) begin
      state_d = BUSY;
      beat_d  = '0;
    end else if (busy && i_ready) begin
      if (last) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d  = beat_q + bw'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      blk_q <= i_mx_vec;
      x_q   <= i_mx_exp;
    end
  end

  for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
    assign o_bf16_vec[gi] = busy ? decode(blk_q[beat_q][gi], x_q) : 16'h0000;
  end

endmodule

// File: tb/tb_conv_mxfp8tobf16.sv
// Directed bench for conv_mxfp8tobf16: E4M3 (sat and non-sat), E5M2 and a
// serialising E4M3 instance with lanes=8, all checked against hand-derived values.
module tb_conv_mxfp8tobf16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errors = 0;
  int   checks = 0;

  // shared stimulus for the three single-beat instances
  logic                s_valid, s_ready;
  logic [31:0][7:0]    s_vec;
  logic [7:0]          s_x;
  logic                a_ready, a_valid, a_last;
  logic [31:0][15:0]   a_vec;
  logic [0:0]          a_beat;
  logic                b_ready, b_valid, b_last;
  logic [31:0][15:0]   b_vec;
  logic [0:0]          b_beat;
  logic                c_ready, c_valid, c_last;
  logic [31:0][15:0]   c_vec;
  logic [0:0]          c_beat;

  // serialising instance
  logic                d_valid, d_ready, d_oready, d_ovalid, d_last;
  logic [31:0][7:0]    d_vec;
  logic [7:0]          d_x;
  logic [7:0][15:0]    d_obf;
  logic [1:0]          d_beat;

  conv_mxfp8tobf16 #(.exp_width(4), .man_width(3), .k(32), .lanes(32), .sat(1'b1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(a_ready), .i_mx_vec(s_vec),
    .i_mx_exp(s_x), .o_valid(a_valid), .i_ready(s_ready), .o_bf16_vec(a_vec),
    .o_beat(a_beat), .o_last(a_last));

  conv_mxfp8tobf16 #(.exp_width(4), .man_width(3), .k(32), .lanes(32), .sat(1'b0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(b_ready), .i_mx_vec(s_vec),
    .i_mx_exp(s_x), .o_valid(b_valid), .i_ready(s_ready), .o_bf16_vec(b_vec),
    .o_beat(b_beat), .o_last(b_last));

  conv_mxfp8tobf16 #(.exp_width(5), .man_width(2), .k(32), .lanes(32), .sat(1'b1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(c_ready), .i_mx_vec(s_vec),
    .i_mx_exp(s_x), .o_valid(c_valid), .i_ready(s_ready), .o_bf16_vec(c_vec),
    .o_beat(c_beat), .o_last(c_last));

  conv_mxfp8tobf16 #(.exp_width(4), .man_width(3), .k(32), .lanes(8), .sat(1'b1)) u_d (
    .i_clk(clk), .i_rst(rst), .i_valid(d_valid), .o_ready(d_oready), .i_mx_vec(d_vec),
    .i_mx_exp(d_x), .o_valid(d_ovalid), .i_ready(d_ready), .o_bf16_vec(d_obf),
    .o_beat(d_beat), .o_last(d_last));

  function automatic logic [31:0][7:0] fill8(input logic [7:0] e);
    logic [31:0][7:0] v;
    for (int i = 0; i < 32; i++) v[i] = e;
    return v;
  endfunction

  function automatic logic [31:0][15:0] fill16(input logic [15:0] e);
    logic [31:0][15:0] v;
    for (int i = 0; i < 32; i++) v[i] = e;
    return v;
  endfunction

  // element i of beat b, lane l: exponent 7+b, mantissa l
  function automatic logic [31:0][7:0] mk_blk(input logic neg);
    logic [31:0][7:0] v;
    for (int i = 0; i < 32; i++) v[i] = {neg, 4'(7 + i / 8), 3'(i % 8)};
    return v;
  endfunction

  // R = 112 + 7 + b -> 0x3B80 + b*0x80, mantissa l -> l<<4
  function automatic logic [7:0][15:0] exp_beat(input logic neg, input int b);
    logic [7:0][15:0] v;
    logic [15:0] t;
    for (int l = 0; l < 8; l++) begin
      t = 16'h3B80 + 16'(b * 128) + 16'(l * 16);
      t[15] = neg;
      v[l] = t;
    end
    return v;
  endfunction

  task automatic send_shared(input logic [31:0][7:0] v, input logic [7:0] x);
    @(negedge clk);
    s_valid = 1'b1;
    s_vec   = v;
    s_x     = x;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    $display("tx shared x=%h e0=%h e1=%h e2=%h -> a0=%h b0=%h c0=%h",
             x, v[0], v[1], v[2], a_vec[0], b_vec[0], c_vec[0]);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_ready = 1'b1; s_vec = fill8(8'h78); s_x = 8'd112;
    d_valid = 1'b1; d_ready = 1'b0; d_vec = mk_blk(1'b0); d_x = 8'd112;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_valid, a_beat, a_last} !== 3'b000) begin
      errors++; $display("FAIL reset_a_ctrl: got %b expected 000", {a_valid, a_beat, a_last});
    end
    checks++;
    if (a_vec !== fill16(16'h0)) begin
      errors++; $display("FAIL reset_a_vec: got %h expected 0", a_vec);
    end
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL reset_a_ready: got %b expected 1", a_ready);
    end
    checks++;
    if ({d_ovalid, d_beat, d_last, d_obf} !== '0) begin
      errors++; $display("FAIL reset_d: got v=%b beat=%0d last=%b vec=%h expected all 0",
                         d_ovalid, d_beat, d_last, d_obf);
    end
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0; d_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (a_valid !== 1'b0 || d_ovalid !== 1'b0) begin
      errors++; $display("FAIL reset_no_accept: got a_valid=%b d_valid=%b expected 0 0", a_valid, d_valid);
    end
  endtask

  task automatic test_normal();
    send_shared(fill8(8'h78), 8'd112);
    checks++;
    if (a_vec !== fill16(16'h3F80)) begin
      errors++; $display("FAIL normal_pos: got %h expected all 3F80", a_vec);
    end
    checks++;
    if ({a_valid, a_last, a_ready, a_beat} !== 4'b1110) begin
      errors++; $display("FAIL normal_ctrl: got %b expected 1110", {a_valid, a_last, a_ready, a_beat});
    end
    checks++;
    if ({b_valid, b_last, b_ready, b_beat, c_valid, c_last, c_ready, c_beat} !== 8'b11101110) begin
      errors++; $display("FAIL normal_ctrl_bc: got %b expected 11101110",
                         {b_valid, b_last, b_ready, b_beat, c_valid, c_last, c_ready, c_beat});
    end
    send_shared(fill8(8'hF8), 8'd112);
    checks++;
    if (a_vec !== fill16(16'hBF80)) begin
      errors++; $display("FAIL normal_neg: got %h expected all BF80", a_vec);
    end
  endtask

  task automatic test_subnormal();
    logic [31:0][7:0]  v;
    logic [31:0][15:0] e;
    v = fill8(8'h00); e = fill16(16'h0000);
    v[0] = 8'h04; e[0] = 16'h3800;
    v[1] = 8'h80; e[1] = 16'h8000;
    v[2] = 8'h03; e[2] = 16'h37C0;
    v[3] = 8'h08; e[3] = 16'h3880;
    send_shared(v, 8'd112);
    checks++;
    if (a_vec !== e) begin
      errors++; $display("FAIL subnormal_x112: got %h expected %h", a_vec, e);
    end
    v = fill8(8'h00); e = fill16(16'h0000);
    v[0] = 8'h01; e[0] = 16'h0000;
    v[1] = 8'h08; e[1] = 16'h0080;
    v[2] = 8'h04; e[2] = 16'h0000;
    v[3] = 8'h88; e[3] = 16'h8080;
    v[4] = 8'h81; e[4] = 16'h8000;
    send_shared(v, 8'd0);
    checks++;
    if (a_vec !== e) begin
      errors++; $display("FAIL underflow_x0: got %h expected %h", a_vec, e);
    end
  endtask

  task automatic test_overflow();
    logic [31:0][7:0]  v;
    logic [31:0][15:0] ea, eb;
    v = fill8(8'h00); ea = fill16(16'h0000); eb = fill16(16'h0000);
    v[0] = 8'h7E; ea[0] = 16'h7F7F; eb[0] = 16'h7F80;
    v[1] = 8'hFE; ea[1] = 16'hFF7F; eb[1] = 16'hFF80;
    v[2] = 8'h7F; ea[2] = 16'h7FC0; eb[2] = 16'h7FC0;
    send_shared(v, 8'd250);
    checks++;
    if (a_vec !== ea) begin
      errors++; $display("FAIL overflow_sat: got %h expected %h", a_vec, ea);
    end
    checks++;
    if (b_vec !== eb) begin
      errors++; $display("FAIL overflow_inf: got %h expected %h", b_vec, eb);
    end
    v = fill8(8'h00); ea = fill16(16'h0000); eb = fill16(16'h0000);
    v[0] = 8'h70; ea[0] = 16'h7F00; eb[0] = 16'h7F00;
    v[1] = 8'h78; ea[1] = 16'h7F7F; eb[1] = 16'h7F80;
    v[2] = 8'hF0; ea[2] = 16'hFF00; eb[2] = 16'hFF00;
    send_shared(v, 8'd240);
    checks++;
    if (a_vec !== ea) begin
      errors++; $display("FAIL edge254_sat: got %h expected %h", a_vec, ea);
    end
    checks++;
    if (b_vec !== eb) begin
      errors++; $display("FAIL edge254_inf: got %h expected %h", b_vec, eb);
    end
  endtask

  task automatic test_nan();
    logic [31:0][7:0]  v;
    logic [31:0][15:0] ea, ec;
    send_shared(fill8(8'h00), 8'hFF);
    checks++;
    if (a_vec !== fill16(16'h7FC0) || c_vec !== fill16(16'h7FC0)) begin
      errors++; $display("FAIL scale_nan: got a=%h c=%h expected all 7FC0", a_vec[0], c_vec[0]);
    end
    v = fill8(8'h00); ea = fill16(16'h0000); ec = fill16(16'h0000);
    v[0] = 8'h7F; ea[0] = 16'h7FC0; ec[0] = 16'h7FC0;
    v[1] = 8'hFF; ea[1] = 16'h7FC0; ec[1] = 16'h7FC0;
    v[2] = 8'h38; ea[2] = 16'h4300; ec[2] = 16'h4680;
    v[3] = 8'hBA; ea[3] = 16'hC320; ec[3] = 16'hC6C0;
    send_shared(v, 8'd127);
    checks++;
    if (a_vec !== ea) begin
      errors++; $display("FAIL elem_nan_e4m3: got %h expected %h", a_vec, ea);
    end
    checks++;
    if (c_vec !== ec) begin
      errors++; $display("FAIL elem_nan_e5m2: got %h expected %h", c_vec, ec);
    end
  endtask

  task automatic test_e5m2();
    logic [31:0][7:0]  v;
    logic [31:0][15:0] ec;
    v = fill8(8'h00); ec = fill16(16'h0000);
    v[0] = 8'h7C; ec[0] = 16'h7F80;
    v[1] = 8'hFC; ec[1] = 16'hFF80;
    v[2] = 8'h7D; ec[2] = 16'h7FC0;
    v[3] = 8'h3C; ec[3] = 16'h3F80;
    send_shared(v, 8'd112);
    checks++;
    if (c_vec !== ec) begin
      errors++; $display("FAIL e5m2_inf: got %h expected %h", c_vec, ec);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    s_valid = 1'b1; s_vec = fill8(8'h78); s_x = 8'd112;
    @(posedge clk);
    #1;
    checks++;
    if (a_vec !== fill16(16'h3F80) || a_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got ready=%b e0=%h expected 1 3F80", a_ready, a_vec[0]);
    end
    @(negedge clk);
    s_vec = fill8(8'hF8);
    @(posedge clk);
    #1;
    checks++;
    if (a_valid !== 1'b1 || a_vec !== fill16(16'hBF80)) begin
      errors++; $display("FAIL b2b_second: got valid=%b e0=%h expected 1 BF80", a_valid, a_vec[0]);
    end
    @(negedge clk);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (a_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got valid=%b expected 0", a_valid);
    end
    $display("tx back_to_back two blocks");
  endtask

  task automatic test_serialise();
    int   eb;
    logic neg;
    logic exp_r;
    @(negedge clk);
    d_valid = 1'b1; d_vec = mk_blk(1'b0); d_x = 8'd112; d_ready = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      d_ready = (c % 2) == 1;
      if (c == 0) d_vec = mk_blk(1'b1);
      if (c == 8) d_valid = 1'b0;
      #1;
      neg   = (c >= 8);
      eb    = (c % 8) / 2;
      exp_r = (c % 8) == 7;
      $display("tx serialise cycle=%0d beat=%0d ready=%b lane0=%h", c, d_beat, d_ready, d_obf[0]);
      checks++;
      if (d_ovalid !== 1'b1 || d_beat !== 2'(eb) || d_last !== (eb == 3)) begin
        errors++; $display("FAIL ser_ctrl c=%0d: got v=%b beat=%0d last=%b expected 1 %0d %b",
                           c, d_ovalid, d_beat, d_last, eb, (eb == 3));
      end
      checks++;
      if (d_oready !== exp_r) begin
        errors++; $display("FAIL ser_oready c=%0d: got %b expected %b", c, d_oready, exp_r);
      end
      checks++;
      if (d_obf !== exp_beat(neg, eb)) begin
        errors++; $display("FAIL ser_data c=%0d: got %h expected %h", c, d_obf, exp_beat(neg, eb));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (d_ovalid !== 1'b0 || d_obf !== '0 || d_oready !== 1'b1) begin
      errors++; $display("FAIL ser_idle: got v=%b ready=%b vec=%h expected 0 1 0", d_ovalid, d_oready, d_obf);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_valid = 1'b1; d_vec = mk_blk(1'b0); d_ready = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    d_valid = 1'b0;
    #1;
    checks++;
    if (d_beat !== 2'd2 || d_obf !== exp_beat(1'b0, 2)) begin
      errors++; $display("FAIL mid_beat2: got beat=%0d vec=%h expected 2 %h", d_beat, d_obf, exp_beat(1'b0, 2));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({d_ovalid, d_beat, d_last} !== 4'b0000 || d_obf !== '0 || d_oready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got v=%b beat=%0d last=%b ready=%b vec=%h expected 0 0 0 1 0",
                         d_ovalid, d_beat, d_last, d_oready, d_obf);
    end
    @(negedge clk);
    rst = 1'b0; d_valid = 1'b1; d_vec = mk_blk(1'b1);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    checks++;
    if (d_ovalid !== 1'b1 || d_beat !== 2'd0 || d_obf !== exp_beat(1'b1, 0)) begin
      errors++; $display("FAIL mid_restart: got v=%b beat=%0d vec=%h expected 1 0 %h",
                         d_ovalid, d_beat, d_obf, exp_beat(1'b1, 0));
    end
    $display("tx reset_mid restart lane0=%h", d_obf[0]);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (d_ovalid !== 1'b0) begin
      errors++; $display("FAIL mid_drain: got v=%b expected 0", d_ovalid);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_subnormal();
    test_overflow();
    test_nan();
    test_e5m2();
    test_back_to_back();
    test_serialise();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_mxfp8tobf16.md
Name: conv_mxfp8tobf16

Overview:
- Decoder from an MX block back to bf16. Input is one block of k narrow FP elements plus a shared 8-bit scale exponent. Output is the same block as bf16 values, serialised over k/lanes output beats.
- Sits on the read-back path after MX storage/compute. It is the inverse of the bf16-to-MX encoder: re-decoding an encoded block reproduces its rounded bf16 values exactly.
- Buffers one block and uses valid/ready handshakes on both sides.

Parameters:
- exp_width, 3, element exponent bits (≥2).
- man_width, 2, element mantissa bits (1..7).
- bit_width, 1+exp_width+man_width, element width.
- k, 32, elements per block.
- lanes, 32, bf16 elements per output beat; k % lanes == 0.
- sat, 1, 1: overflow saturates to ±max finite bf16; 0: overflow gives ±Inf.
- e4m3_spec, (exp_width==4)&&(man_width==3), OCP E4M3 special-value encoding.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input block valid.
- o_ready  out  1  block accepted when i_valid && o_ready.
- i_mx_vec  in  [bit_width-1:0] x k  elements, {sign, exp, man}.
- i_mx_exp  in  8  shared scale X.
- o_valid  out  1  output beat valid.
- i_ready  in  1  beat consumed when o_valid && i_ready.
- o_bf16_vec  out  [15:0] x lanes  decoded elements, beat b carries elements b*lanes .. b*lanes+lanes-1.
- o_beat  out  max(1,$clog2(k/lanes))  current beat index.
- o_last  out  1  high on beat k/lanes-1.

Behaviour:
- State:
  - busy flag; beat counter.
  - Block buffer holding all element bits and X.
- Reset (i_rst=1 at a clock edge):
  - busy=0, beat=0, so o_valid=0.
  - o_bf16_vec=0, o_beat=0, o_last=0.
  - Buffer contents don't-care.
  - Reset mid-block discards the remaining beats.
- Output gating: o_valid=busy. While o_valid=0, o_bf16_vec, o_beat and o_last are forced to 0.
- Ready: o_ready = !busy || (o_valid && i_ready && o_last). This is combinational from state and i_ready, and gives full throughput when lanes==k.
- Accept (i_valid && o_ready at edge t):
  - Buffer loads the block.
  - busy=1, beat=0.
  - First beat is valid from cycle t+1, so latency is 1 cycle.
- Beat consumption (o_valid && i_ready):
  - Not last beat: beat increments.
  - Last beat with a simultaneous accept: buffer reloads, beat=0, busy stays 1.
  - Last beat with no accept: busy=0, beat=0.
- Stall: with o_valid && !i_ready, all outputs hold stable.
- Decode, per element {s,E,M}. Result exponent R is computed at ≥10-bit signed width.
  - Normal, E≠0: R = X + E; bf16 mantissa = {M, (7-man_width) zeros}.
  - Subnormal, E=0 and M≠0:
    - p = index of the leading one of M.
    - R = X + 1 - (man_width - p).
    - bf16 mantissa = bits of M below p, left-aligned, zero-filled.
  - Zero, E=0 and M=0: ±0, i.e. {s, 15'b0}.
  - R ≥ 255: sat=1 gives {s,15'h7F7F}; sat=0 gives {s,15'h7F80}.
  - R ≤ 0: flush to {s,15'b0}.
  - Otherwise: {s, R[7:0], mantissa}.
- NaN handling. Each of the following yields 16'h7FC0 regardless of s:
  - X == 8'hFF: every element of the block is NaN.
  - e4m3_spec=1: an element with E and M all ones (e.g. 0x7F, 0xFF) is NaN. E=1111 with M≠111 is normal.
  - e4m3_spec=0, E all ones and M≠0: NaN.
- Inf handling, e4m3_spec=0 only: E all ones and M==0 gives ±Inf {s,15'h7F80}. This applies even when sat=1.
- Precedence: scale NaN > element NaN/Inf > zero > overflow > underflow > finite.
- No rounding is required, since every element mantissa fits in 7 bits.

Test Plan:
- E4M3, k=lanes=32: X=112, all elements 0x78 -> one beat 1 cycle after accept, all 16'h3F80, o_last=1. Repeat with element 0xF8 -> all 16'hBF80.
- E4M3 subnormal/zero: X=112, element 0x04 -> 16'h3800; element 0x80 -> 16'h8000; X=0, element 0x01 -> 16'h0000 (underflow flush).
- E4M3 overflow: X=250, element 0x7E, sat=1 -> 16'h7F7F; element 0xFE with sat=0 -> 16'hFF80.
- NaN: X=8'hFF -> all 16'h7FC0. X=127, element 0x7F -> 16'h7FC0 while neighbours decode normally. E5M2 (e4m3_spec=0) element 0x7C -> 16'h7F80.
- Serialisation, k=32, lanes=8, two back-to-back blocks:
  - i_ready toggles 1,0,1,…; beats 0..3 are presented in order and held stable while stalled.
  - o_ready is low during beats 0..2 and high on the consumed last beat.
  - The second block's beat 0 follows with no bubble.
- Reset mid-block: assert i_rst during beat 2 of 4 -> next cycle o_valid=0, o_ready=1, outputs 0. A new block then starts at beat 0.
